// File: rtl/sal_sdp_ram.sv
// Simple dual-port RAM: one write port (A), one read port (B), single clock.
// Optional output register and selectable same-address read/write policy.
module sal_sdp_ram #(
    parameter int DEPTH_LG2    = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int RDATA_FF_OUT = 0,
    parameter     RW_SYNC      = "RD_FIRST"
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  en_a,
    input  logic                  we_a,
    input  logic [DEPTH_LG2-1:0]  addr_a,
    input  logic [DATA_WIDTH-1:0] di_a,
    input  logic                  en_b,
    input  logic [DEPTH_LG2-1:0]  addr_b,
    output logic [DATA_WIDTH-1:0] do_b
);

    localparam int DEPTH = 1 << DEPTH_LG2;
    localparam bit IS_RD = (RW_SYNC == "RD_FIRST");
    localparam bit IS_WR = (RW_SYNC == "WR_FIRST");

    generate
        if (!(IS_RD || IS_WR) || DEPTH_LG2 < 1 || DATA_WIDTH < 1) begin : g_bad_param
            $error("sal_sdp_ram: illegal RW_SYNC, DEPTH_LG2 or DATA_WIDTH");
        end
    endgenerate

    // Zero contents are a power-up value only; srst never touches the array.
    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};
    logic [DATA_WIDTH-1:0] rd_q;
    logic                  wr;
    logic                  bypass;

    assign wr     = en_a && we_a;
    assign bypass = IS_WR && wr && (addr_a == addr_b);

    always_ff @(posedge clk) begin
        if (!srst && wr) begin
            mem[addr_a] <= di_a;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            rd_q <= '0;
        end else if (en_b) begin
            rd_q <= bypass ? di_a : mem[addr_b];
        end
    end

    generate
        if (RDATA_FF_OUT != 0) begin : g_out_ff
            logic [DATA_WIDTH-1:0] out_q;

            always_ff @(posedge clk) begin
                if (srst) begin
                    out_q <= '0;
                end else begin
                    out_q <= rd_q;
                end
            end

            assign do_b = out_q;
        end else begin : g_no_out_ff
            assign do_b = rd_q;
        end
    endgenerate

endmodule

// File: tb/tb_sal_sdp_ram.sv
// Directed bench for sal_sdp_ram: three instances cover output-register
// latency and both collision policies from one shared stimulus stream.
module tb_sal_sdp_ram;

    logic       clk = 1'b0;
    logic       srst;
    logic       en_a;
    logic       we_a;
    logic [3:0] addr_a;
    logic [7:0] di_a;
    logic       en_b;
    logic [3:0] addr_b;
    logic [7:0] do_rf;
    logic [7:0] do_ff;
    logic [7:0] do_wf;

    int errors = 0;
    int checks = 0;
    logic [7:0] model [16];

    always #5 clk = ~clk;

    sal_sdp_ram #(
        .DEPTH_LG2(4), .DATA_WIDTH(8), .RDATA_FF_OUT(0), .RW_SYNC("RD_FIRST")
    ) u_rf (
        .clk(clk), .srst(srst), .en_a(en_a), .we_a(we_a), .addr_a(addr_a),
        .di_a(di_a), .en_b(en_b), .addr_b(addr_b), .do_b(do_rf)
    );

    sal_sdp_ram #(
        .DEPTH_LG2(4), .DATA_WIDTH(8), .RDATA_FF_OUT(1), .RW_SYNC("RD_FIRST")
    ) u_ff (
        .clk(clk), .srst(srst), .en_a(en_a), .we_a(we_a), .addr_a(addr_a),
        .di_a(di_a), .en_b(en_b), .addr_b(addr_b), .do_b(do_ff)
    );

    sal_sdp_ram #(
        .DEPTH_LG2(4), .DATA_WIDTH(8), .RDATA_FF_OUT(0), .RW_SYNC("WR_FIRST")
    ) u_wf (
        .clk(clk), .srst(srst), .en_a(en_a), .we_a(we_a), .addr_a(addr_a),
        .di_a(di_a), .en_b(en_b), .addr_b(addr_b), .do_b(do_wf)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%02h expected=%02h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en_a = 1'b0; we_a = 1'b0; addr_a = '0; di_a = '0;
        en_b = 1'b0; addr_b = '0;
    endtask

    initial begin
        srst = 1'b1;
        idle();
        cyc();
        chk("reset_rf", do_rf, 8'h00);
        chk("reset_ff", do_ff, 8'h00);
        chk("reset_wf", do_wf, 8'h00);
        srst = 1'b0;

        // basic write then read, latency 1 vs 2
        en_a = 1'b1; we_a = 1'b1; addr_a = 4'd3; di_a = 8'hA5;
        cyc();
        idle();
        en_b = 1'b1; addr_b = 4'd3;
        cyc();
        en_b = 1'b0;
        chk("basic_lat1", do_rf, 8'hA5);
        chk("ff_not_at_1", do_ff, 8'h00);
        cyc();
        chk("ff_lat2", do_ff, 8'hA5);
        chk("basic_hold", do_rf, 8'hA5);
        cyc();
        chk("ff_hold", do_ff, 8'hA5);

        // same-address collision
        en_a = 1'b1; we_a = 1'b1; addr_a = 4'd5; di_a = 8'h11;
        cyc();
        di_a = 8'h22; en_b = 1'b1; addr_b = 4'd5;
        cyc();
        chk("coll_rd_first", do_rf, 8'h11);
        chk("coll_wr_first", do_wf, 8'h22);
        idle();
        en_b = 1'b1; addr_b = 4'd5;
        cyc();
        idle();
        chk("coll_reread_rf", do_rf, 8'h22);
        chk("coll_reread_wf", do_wf, 8'h22);
        chk("coll_ff_pipe", do_ff, 8'h11);

        // fill, then reset with write and read attempts in flight
        for (int i = 0; i < 16; i++) begin
            en_a = 1'b1; we_a = 1'b1; addr_a = 4'(i); di_a = 8'(i);
            cyc();
        end
        en_b = 1'b1; addr_b = 4'd9;
        srst = 1'b1; di_a = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            addr_a = 4'(i * 7);
            cyc();
            chk("srst_rf", do_rf, 8'h00);
            chk("srst_ff", do_ff, 8'h00);
            chk("srst_wf", do_wf, 8'h00);
        end
        srst = 1'b0;
        idle();
        for (int i = 0; i < 16; i++) begin
            en_b = 1'b1; addr_b = 4'(i);
            cyc();
            chk("post_srst_rf", do_rf, 8'(i));
            chk("post_srst_ff", do_ff, (i == 0) ? 8'h00 : 8'(i - 1));
        end
        idle();
        for (int i = 0; i < 16; i++) model[i] = 8'(i);

        // streaming: write k, read k-1, then wrap to address 0
        for (int k = 0; k < 18; k++) begin
            logic [3:0] ra;
            logic [7:0] wv;
            ra = 4'((k - 1) & 15);
            en_a = (k < 17); we_a = en_a;
            addr_a = (k < 16) ? 4'(k) : 4'd0;
            wv = (k < 16) ? 8'(8'h40 + k) : 8'h80;
            di_a = wv;
            en_b = (k > 0);
            addr_b = (k == 17) ? 4'd0 : ra;
            cyc();
            if (k > 0) begin
                chk("stream_rf", do_rf, model[addr_b]);
                chk("stream_wf", do_wf, model[addr_b]);
            end
            if (en_a) model[addr_a] = wv;
        end
        idle();
        chk("wrap_addr0", do_rf, 8'h80);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
